// File: rtl/axi4_rr_arbiter.sv
// axi4_rr_arbiter: round-robin N-to-1 AXI4 arbiter, one burst at a time; ports s_* per-requester packed lanes, m_* shared master, id=grant
module axi4_rr_arbiter #(
  parameter int N   = 2,
  parameter int IDW = 4
) (
  input  logic            clock,
  input  logic            rst_i,
  input  logic [N-1:0]    s_arvalid,
  output logic [N-1:0]    s_arready,
  input  logic [N*32-1:0] s_araddr,
  input  logic [N*8-1:0]  s_arlen,
  input  logic [N*3-1:0]  s_arsize,
  input  logic [N-1:0]    s_awvalid,
  output logic [N-1:0]    s_awready,
  input  logic [N*32-1:0] s_awaddr,
  input  logic [N*8-1:0]  s_awlen,
  input  logic [N*3-1:0]  s_awsize,
  input  logic [N-1:0]    s_wvalid,
  input  logic [N-1:0]    s_wlast,
  output logic [N-1:0]    s_wready,
  input  logic [N*32-1:0] s_wdata,
  input  logic [N*4-1:0]  s_wstrb,
  output logic [N-1:0]    s_rvalid,
  output logic [N-1:0]    s_rlast,
  input  logic [N-1:0]    s_rready,
  input  logic [N-1:0]    s_bready,
  output logic [31:0]     s_rdata,
  output logic [1:0]      s_rresp,
  output logic [1:0]      s_bresp,
  output logic [N-1:0]    s_bvalid,
  output logic            m_arvalid,
  input  logic            m_arready,
  output logic [IDW-1:0]  m_arid,
  output logic [31:0]     m_araddr,
  output logic [7:0]      m_arlen,
  output logic [2:0]      m_arsize,
  output logic [1:0]      m_arburst,
  output logic            m_awvalid,
  input  logic            m_awready,
  output logic [IDW-1:0]  m_awid,
  output logic [31:0]     m_awaddr,
  output logic [7:0]      m_awlen,
  output logic [2:0]      m_awsize,
  output logic [1:0]      m_awburst,
  output logic            m_wvalid,
  input  logic            m_wready,
  output logic [31:0]     m_wdata,
  output logic [3:0]      m_wstrb,
  output logic            m_wlast,
  input  logic            m_rvalid,
  output logic            m_rready,
  input  logic [IDW-1:0]  m_rid,
  input  logic [31:0]     m_rdata,
  input  logic [1:0]      m_rresp,
  input  logic            m_rlast,
  input  logic            m_bvalid,
  output logic            m_bready,
  input  logic [IDW-1:0]  m_bid,
  input  logic [1:0]      m_bresp
);
  localparam int GW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [2:0] {IDLE, AR, R, AW, W, B} state_t;
  state_t state;
  logic [GW-1:0] grant, rr_ptr, pick, nxt;
  logic [N-1:0] req, oh;
  logic unused_ids;
  assign unused_ids = ^{m_rid, m_bid};
  assign req = s_arvalid | s_awvalid;
  assign oh = N'(1) << grant;
  assign nxt = (grant == GW'(N - 1)) ? '0 : grant + 1'b1;
  always_comb begin
    pick = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(rr_ptr) + k) % N]) pick = GW'((int'(rr_ptr) + k) % N);
  end
  always_ff @(posedge clock or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        IDLE: if (|req) begin
          grant <= pick;
          state <= s_arvalid[pick] ? AR : AW;
        end
        AR: if (m_arready) state <= R;
        R: if (m_rvalid && m_rready && m_rlast) begin
          state  <= IDLE;
          rr_ptr <= nxt;
        end
        AW: if (m_awready) state <= W;
        W: if (m_wvalid && m_wready && m_wlast) state <= B;
        B: if (m_bvalid && m_bready) begin
          state  <= IDLE;
          rr_ptr <= nxt;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign m_arvalid = state == AR;
  assign m_arid    = IDW'(grant);
  assign m_araddr  = s_araddr[32*grant +: 32];
  assign m_arlen   = s_arlen[8*grant +: 8];
  assign m_arsize  = s_arsize[3*grant +: 3];
  assign m_arburst = 2'b01;
  assign s_arready = (state == AR && m_arready) ? oh : '0;
  assign m_awvalid = state == AW;
  assign m_awid    = IDW'(grant);
  assign m_awaddr  = s_awaddr[32*grant +: 32];
  assign m_awlen   = s_awlen[8*grant +: 8];
  assign m_awsize  = s_awsize[3*grant +: 3];
  assign m_awburst = 2'b01;
  assign s_awready = (state == AW && m_awready) ? oh : '0;
  assign m_wvalid  = state == W && s_wvalid[grant];
  assign m_wdata   = s_wdata[32*grant +: 32];
  assign m_wstrb   = s_wstrb[4*grant +: 4];
  assign m_wlast   = s_wlast[grant];
  assign s_wready  = (state == W && m_wready) ? oh : '0;
  assign m_rready  = state == R && s_rready[grant];
  assign s_rvalid  = (state == R && m_rvalid) ? oh : '0;
  assign s_rlast   = (state == R && m_rlast) ? oh : '0;
  assign s_rdata   = m_rdata;
  assign s_rresp   = m_rresp;
  assign m_bready  = state == B && s_bready[grant];
  assign s_bvalid  = (state == B && m_bvalid) ? oh : '0;
  assign s_bresp   = m_bresp;
endmodule

// File: tb/tb_axi4_rr_arbiter.sv
// tb_axi4_rr_arbiter: directed bench with a transaction-level model compared every cycle
module tb_axi4_rr_arbiter;
  localparam int N = 2;
  localparam int IDW = 4;
  logic clock = 1'b0;
  logic rst_i = 1'b1;
  logic [N-1:0] s_arvalid = '0, s_awvalid = '0, s_wvalid = '0, s_wlast = '0, s_rready = '0, s_bready = '0;
  logic [N-1:0] s_arready, s_awready, s_wready, s_rvalid, s_rlast, s_bvalid;
  logic [N*32-1:0] s_araddr = '0, s_awaddr = '0, s_wdata = '0;
  logic [N*8-1:0] s_arlen = '0, s_awlen = '0;
  logic [N*3-1:0] s_arsize = '0, s_awsize = '0;
  logic [N*4-1:0] s_wstrb = '0;
  logic [31:0] s_rdata;
  logic [1:0] s_rresp, s_bresp;
  logic m_arvalid, m_awvalid, m_wvalid, m_wlast, m_rready, m_bready;
  logic m_arready = 0, m_awready = 0, m_wready = 0, m_rvalid = 0, m_rlast = 0, m_bvalid = 0;
  logic [IDW-1:0] m_arid, m_awid;
  logic [IDW-1:0] m_rid = '0, m_bid = '0;
  logic [31:0] m_araddr, m_awaddr, m_wdata;
  logic [31:0] m_rdata = '0;
  logic [7:0] m_arlen, m_awlen;
  logic [2:0] m_arsize, m_awsize;
  logic [1:0] m_arburst, m_awburst;
  logic [3:0] m_wstrb;
  logic [1:0] m_rresp = '0, m_bresp = '0;
  int total = 0, bad = 0;
  int rbeats [N];
  int bbeats [N];
  logic [1:0] last_bresp = 2'b11;
  bit open = 0, wr = 0, adone = 0, wdone = 0;
  int g = 0, rr = 0;

  axi4_rr_arbiter #(.N(N), .IDW(IDW)) dut (
    .clock(clock), .rst_i(rst_i),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_wvalid(s_wvalid), .s_wlast(s_wlast), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_rvalid(s_rvalid), .s_rlast(s_rlast), .s_rready(s_rready), .s_bready(s_bready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_bresp(s_bresp), .s_bvalid(s_bvalid),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // transaction-level model: one open burst, addressed then data then (writes) response
  always @(posedge clock or posedge rst_i) begin
    if (rst_i) begin
      open = 0; rr = 0; g = 0;
    end else if (!open) begin
      for (int k = N - 1; k >= 0; k--)
        if (s_arvalid[(rr + k) % N] || s_awvalid[(rr + k) % N]) begin
          open = 1; g = (rr + k) % N;
        end
      if (open) begin
        wr = !s_arvalid[g]; adone = 0; wdone = 0;
      end
    end else if (!adone) begin
      if (wr ? m_awready : m_arready) adone = 1;
    end else if (!wr) begin
      if (m_rvalid && s_rready[g] && m_rlast) begin open = 0; rr = (g + 1) % N; end
    end else if (!wdone) begin
      if (s_wvalid[g] && m_wready && s_wlast[g]) wdone = 1;
    end else if (m_bvalid && s_bready[g]) begin
      open = 0; rr = (g + 1) % N;
    end
  end

  task automatic compare();
    logic [N-1:0] oh;
    bit aph, rph, wph, bph;
    oh = '0;
    if (open) oh[g] = 1'b1;
    aph = open && !adone;
    rph = open && !wr && adone;
    wph = open && wr && adone && !wdone;
    bph = open && wr && wdone;
    chk("m_arvalid", m_arvalid, aph && !wr);
    chk("m_awvalid", m_awvalid, aph && wr);
    chk("s_arready", s_arready, (aph && !wr && m_arready) ? oh : '0);
    chk("s_awready", s_awready, (aph && wr && m_awready) ? oh : '0);
    chk("m_wvalid", m_wvalid, wph && s_wvalid[g]);
    chk("s_wready", s_wready, (wph && m_wready) ? oh : '0);
    chk("m_rready", m_rready, rph && s_rready[g]);
    chk("s_rvalid", s_rvalid, (rph && m_rvalid) ? oh : '0);
    chk("s_rlast", s_rlast, (rph && m_rlast) ? oh : '0);
    chk("m_bready", m_bready, bph && s_bready[g]);
    chk("s_bvalid", s_bvalid, (bph && m_bvalid) ? oh : '0);
    if (aph && !wr) begin
      chk("m_arid", m_arid, g);
      chk("m_araddr", m_araddr, s_araddr[32*g +: 32]);
      chk("m_arlen", m_arlen, s_arlen[8*g +: 8]);
      chk("m_arburst", m_arburst, 2'b01);
    end
    if (aph && wr) begin
      chk("m_awid", m_awid, g);
      chk("m_awaddr", m_awaddr, s_awaddr[32*g +: 32]);
      chk("m_awlen", m_awlen, s_awlen[8*g +: 8]);
      chk("m_awburst", m_awburst, 2'b01);
    end
    if (wph) begin
      chk("m_wdata", m_wdata, s_wdata[32*g +: 32]);
      chk("m_wstrb", m_wstrb, s_wstrb[4*g +: 4]);
      chk("m_wlast", m_wlast, s_wlast[g]);
    end
    if (rph) chk("s_rdata", s_rdata, m_rdata);
    if (bph) chk("s_bresp", s_bresp, m_bresp);
  endtask

  initial begin
    @(posedge clock);
    forever begin
      @(negedge clock);
      compare();
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin rbeats[i] = 0; bbeats[i] = 0; end
    forever begin
      @(negedge clock);
      for (int i = 0; i < N; i++) begin
        if (s_rvalid[i] && s_rready[i]) rbeats[i]++;
        if (s_bvalid[i] && s_bready[i]) begin bbeats[i]++; last_bresp = s_bresp; end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // acts as the downstream slave; write data comes from the granted requester lane
  task automatic serve(output int id, output bit w, input int ad, input int nb, input int st, input bit drop);
    int n;
    n = 0;
    while (!(m_arvalid || m_awvalid) && n < 50) begin step(); n++; end
    if (n >= 50) begin
      total++; bad++;
      $display("FAIL wait_addr got=timeout want=address_valid");
      id = -1; w = 0;
      return;
    end
    w = m_awvalid;
    id = w ? int'(m_awid) : int'(m_arid);
    if (w) begin
      s_wvalid[id] = 1'b1;
      s_wdata[32*id +: 32] = 32'hB000_0000;
      s_wstrb[4*id +: 4] = 4'hF;
      s_wlast[id] = nb == 1;
    end
    for (int i = 0; i < ad; i++) begin
      if (w) chk("wvalid_before_aw", m_wvalid, 0);
      step();
    end
    if (w) m_awready = 1; else m_arready = 1;
    step();
    m_arready = 0; m_awready = 0;
    if (drop) begin
      if (w) s_awvalid[id] = 0; else s_arvalid[id] = 0;
    end
    if (!w) begin
      for (int b = 0; b < nb; b++) begin
        m_rvalid = 1; m_rdata = 32'hA000_0000 + 32'(id * 16 + b); m_rlast = b == nb - 1;
        s_rready[id] = 0;
        if (b == 0)
          for (int s = 0; s < st; s++) begin
            step();
            chk("stall_rready", m_rready, 0);
          end
        s_rready[id] = 1;
        step();
      end
      m_rvalid = 0; m_rlast = 0; s_rready[id] = 0;
    end else begin
      m_wready = 1;
      for (int b = 0; b < nb; b++) begin
        s_wdata[32*id +: 32] = 32'hB000_0000 + 32'(b);
        s_wlast[id] = b == nb - 1;
        step();
      end
      m_wready = 0; s_wvalid[id] = 0; s_wlast[id] = 0;
      m_bvalid = 1; m_bresp = 2'b00; s_bready[id] = 1;
      step();
      m_bvalid = 0; s_bready[id] = 0;
    end
  endtask

  initial begin
    int id, r0, r1, b0;
    bit w;
    int ord [4];
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1);
  end

  initial begin
    int id, r0, r1, b0;
    bit w;
    int ord [4];
    repeat (3) @(posedge clock);
    #1 rst_i = 0;
    chk("rst_m_arvalid", m_arvalid, 0);
    chk("rst_m_rready", m_rready, 0);
    chk("rst_s_arready", s_arready, 0);
    // single read from requester 1, four beats
    r0 = rbeats[0]; r1 = rbeats[1];
    s_arvalid[1] = 1; s_araddr[63:32] = 32'h8000_0000; s_arlen[15:8] = 8'd3;
    chk("t1_arvalid_cycle0", m_arvalid, 0);
    step();
    chk("t1_arvalid_cycle1", m_arvalid, 1);
    chk("t1_arid", m_arid, 1);
    chk("t1_araddr", m_araddr, 32'h8000_0000);
    serve(id, w, 0, 4, 0, 1);
    chk("t1_grant", id, 1);
    chk("t1_beats1", rbeats[1] - r1, 4);
    chk("t1_beats0", rbeats[0] - r0, 0);
    // both requesters hold reads: alternate starting at 0
    s_arvalid = 2'b11; s_araddr = {32'h0000_2000, 32'h0000_1000}; s_arlen = '0;
    for (int t = 0; t < 4; t++) serve(ord[t], w, 0, 1, 0, 0);
    s_arvalid = '0;
    chk("t2_ord0", ord[0], 0);
    chk("t2_ord1", ord[1], 1);
    chk("t2_ord2", ord[2], 0);
    chk("t2_ord3", ord[3], 1);
    s_arvalid = 2'b11;
    serve(id, w, 0, 1, 0, 0);
    s_arvalid = '0;
    chk("t2_ptr_back_to_0", id, 0);
    // requester 0 write, AW ready held off three cycles
    b0 = bbeats[0];
    s_awvalid[0] = 1; s_awaddr[31:0] = 32'h0000_0F00; s_awlen[7:0] = 8'd1;
    serve(id, w, 3, 2, 0, 1);
    chk("t3_is_write", w, 1);
    chk("t3_grant", id, 0);
    chk("t3_bcount", bbeats[0] - b0, 1);
    chk("t3_bresp", last_bresp, 2'b00);
    // read and write together from requester 0: read goes first
    s_arvalid[0] = 1; s_awvalid[0] = 1; s_araddr[31:0] = 32'h0000_3000; s_awaddr[31:0] = 32'h0000_4000;
    serve(id, w, 0, 1, 0, 1);
    chk("t4_first_is_read", w, 0);
    chk("t4_first_grant", id, 0);
    serve(id, w, 1, 1, 0, 1);
    chk("t4_second_is_write", w, 1);
    chk("t4_second_grant", id, 0);
    // requester 1 stalls the first read beat for five cycles
    r1 = rbeats[1];
    s_arvalid[1] = 1; s_arlen[15:8] = 8'd3;
    serve(id, w, 0, 4, 5, 1);
    chk("t5_grant", id, 1);
    chk("t5_beats", rbeats[1] - r1, 4);
    // advance pointer to 1, then reset in the middle of a read from requester 1
    s_arvalid[0] = 1; s_arlen = '0;
    serve(id, w, 0, 1, 0, 1);
    s_arvalid[1] = 1;
    step();
    chk("t6_arvalid", m_arvalid, 1);
    chk("t6_arid", m_arid, 1);
    m_arready = 1;
    step();
    m_arready = 0; s_arvalid[1] = 0; m_rvalid = 1; s_rready[1] = 1;
    #1 chk("t6_rready_before", m_rready, 1);
    #1 rst_i = 1;
    #1 chk("t6_rst_rready", m_rready, 0);
    chk("t6_rst_rvalid", s_rvalid, 0);
    m_rvalid = 0; s_rready = '0;
    step();
    rst_i = 0;
    s_arvalid = 2'b11;
    serve(id, w, 0, 1, 0, 0);
    s_arvalid = '0;
    chk("t6_grant_after_reset", id, 0);
    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
